hpf_z_packer: RTL



---
 rtl/hpf_z_packer_pkg.sv | 14 +
 rtl/hpf_word_fifo.sv | 76 +++++++
 rtl/hpf_z_packer.sv | 94 +++++++++
 3 files changed

// File: rtl/hpf_z_packer_pkg.sv
// Shared widths, default FIFO depth and packer state encoding for the
// high-pass filter output packer.
package hpf_pkg;

  localparam int SAMPLE_W   = 8;
  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/hpf_word_fifo.sv
// Generic synchronous FIFO with level tracking and synchronous flush.
// Head word is read combinationally from the register array.
module hpf_word_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic          push_ok,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic          pop_ok;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_q];

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_d = rd_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level_d = level_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/hpf_z_packer.sv
// Captures one filtered sample per z_valid strobe, packs pairs as
// {second, first} into 16-bit words and queues them for downstream.
module hpf_z_packer
  import hpf_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                z_valid,
  input  logic [SAMPLE_W-1:0] z,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [WORD_W-1:0]   out_data,
  output logic [AW:0]         level,
  output logic                overflow
);

  pack_state_e         state_q, state_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                z_valid_d_q;
  logic                overflow_q, overflow_d;
  logic                cap;
  logic                push;
  logic                pop;
  logic                push_ok;
  logic                fifo_empty;
  logic                fifo_full;

  assign cap  = z_valid & ~z_valid_d_q;
  assign push = (state_q == HALF) & cap & ~flush;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    overflow_d = overflow_q;
    if (flush) begin
      state_d    = EMPTY;
      overflow_d = 1'b0;
    end else if (cap) begin
      unique case (state_q)
        EMPTY: begin
          hold_d  = z;
          state_d = HALF;
        end
        HALF: begin
          // The pair is consumed even if the FIFO rejects it.
          state_d = EMPTY;
          if (!push_ok) overflow_d = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      z_valid_d_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      z_valid_d_q <= z_valid;
      overflow_q  <= overflow_d;
    end
  end

  hpf_word_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wdata   ({z, hold_q}),
    .push_ok (push_ok),
    .rdata   (out_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

endmodule
